// File: rtl/adder_pkg.sv
// adder_pkg: FSM state encoding, mode constants and sizing helper shared by the serial adder.
`default_nettype none

package adder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIN  = 2'd2
   } state_e;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

   // Digit counter width; a single-slice operation still needs a 1-bit counter.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

`default_nettype wire

// File: rtl/digit_adder.sv
// digit_adder: W-bit ripple-carry slice adder; also exposes the carry into its MSB for overflow detection.
`default_nettype none

module digit_adder #(
   parameter int W = 1
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         cin_i,
   output logic [W-1:0] sum_o,
   output logic         cout_o,
   output logic         cmsb_o
);

   logic [W:0] carry;

   always_comb begin
      carry    = '0;
      sum_o    = '0;
      carry[0] = cin_i;
      for (int i = 0; i < W; i++) begin
         sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
         carry[i+1]   = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
      end
   end

   assign cout_o = carry[W];
   assign cmsb_o = carry[W-1];

endmodule

`default_nettype wire

// File: rtl/serial_adder_n.sv
// serial_adder_n: digit-serial adder/subtractor processing DIGIT bits per cycle, LSB slice first.
`default_nettype none

module serial_adder_n
   import adder_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic             mode_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             cin_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] s_o,
   output logic             cout_o,
   output logic             ovf_o
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = cnt_width(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   generate
      if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
         $error("serial_adder_n: WIDTH must be in 2..64");
      end
      if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
         $error("serial_adder_n: DIGIT must divide WIDTH exactly");
      end
   endgenerate

   state_e           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] acc_q;
   logic             carry_q;
   logic [CW-1:0]    cnt_q;

   logic [DIGIT-1:0] sl_sum;
   logic             sl_cout;
   logic             sl_cmsb;
   logic [WIDTH-1:0] acc_d;
   logic [WIDTH-1:0] b_eff;
   logic             cin_eff;

   // Subtraction is A + ~B + 1: B is inverted once at launch, carry seeded to 1.
   assign b_eff   = (mode_i == MODE_SUB) ? ~b_i : b_i;
   assign cin_eff = (mode_i == MODE_SUB) ? 1'b1 : cin_i;

   digit_adder #(
      .W (DIGIT)
   ) u_digit (
      .a_i    (a_q[DIGIT-1:0]),
      .b_i    (b_q[DIGIT-1:0]),
      .cin_i  (carry_q),
      .sum_o  (sl_sum),
      .cout_o (sl_cout),
      .cmsb_o (sl_cmsb)
   );

   // New slice enters at the top; after N shifts the LSB slice sits at bit 0.
   assign acc_d = WIDTH'({sl_sum, acc_q} >> DIGIT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         busy_o  <= 1'b0;
         done_o  <= 1'b0;
         s_o     <= '0;
         cout_o  <= 1'b0;
         ovf_o   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  a_q     <= a_i;
                  b_q     <= b_eff;
                  carry_q <= cin_eff;
                  cnt_q   <= '0;
                  busy_o  <= 1'b1;
                  state_q <= ST_RUN;
               end
            end
            ST_RUN: begin
               a_q     <= a_q >> DIGIT;
               b_q     <= b_q >> DIGIT;
               acc_q   <= acc_d;
               carry_q <= sl_cout;
               cnt_q   <= cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  cnt_q   <= '0;
                  busy_o  <= 1'b0;
                  done_o  <= 1'b1;
                  s_o     <= acc_d;
                  cout_o  <= sl_cout;
                  ovf_o   <= sl_cmsb ^ sl_cout;
                  state_q <= ST_FIN;
               end
            end
            ST_FIN: begin
               done_o <= 1'b0;
               if (start_i) begin
                  a_q     <= a_i;
                  b_q     <= b_eff;
                  carry_q <= cin_eff;
                  cnt_q   <= '0;
                  busy_o  <= 1'b1;
                  state_q <= ST_RUN;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               busy_o  <= 1'b0;
               done_o  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: doc/serial_adder_n.md
SERIAL_ADDER_N -- requirements
Module: serial_adder_n

Interface
REQ-001 Parameter WIDTH, default 8: operand and sum width in bits; legal range 2..64.
REQ-002 Parameter DIGIT, default 1: bits processed per cycle; SHALL divide WIDTH exactly (elaboration error otherwise).
REQ-003 CLOCK  input  1  single system clock; all state updates on its rising edge.
REQ-004 RESETN  input  1  asynchronous, active-low reset.
REQ-005 START  input  1  request pulse; sampled on CLOCK rising edge.
REQ-006 MODE  input  1  0 = add (A+B+CIN), 1 = subtract (A-B, i.e. A+~B+1, CIN ignored).
REQ-007 A  input  WIDTH  operand A, two's complement or unsigned.
REQ-008 B  input  WIDTH  operand B.
REQ-009 CIN  input  1  carry-in for add mode.
REQ-010 BUSY  output  1  high while an operation is in progress.
REQ-011 DONE  output  1  one-cycle pulse, result valid.
REQ-012 S  output  WIDTH  sum/difference.
REQ-013 COUT  output  1  final carry-out (subtract: 1 = no borrow).
REQ-014 OVF  output  1  signed overflow of the final result.

Function
REQ-015 Define N = WIDTH/DIGIT; the FSM SHALL have states IDLE, RUN, FIN.
REQ-016 IDLE, START=1: latch A, B (inverted if MODE=1) and carry (CIN, or 1 if MODE=1); clear digit counter; go to RUN.
REQ-017 RUN: each cycle add one DIGIT-bit slice, LSB slice first, with the registered carry; store the slice result and update the carry.
REQ-018 RUN SHALL last exactly N cycles; after slice N-1 is stored, go to FIN.
REQ-019 FIN: DONE=1 for exactly one cycle; next state is IDLE, or RUN with new operands latched if START=1 in that cycle.
REQ-020 Latency: if START is sampled at edge 0, DONE SHALL be high in the cycle following edge N.
REQ-021 BUSY SHALL be 1 exactly in RUN; it is 0 in IDLE and FIN.
REQ-022 START in RUN SHALL be ignored; A, B, MODE and CIN changes during RUN SHALL not affect the result.
REQ-023 S, COUT and OVF SHALL update only on the FIN transition, and hold until the next FIN or reset.
REQ-024 OVF SHALL equal the carry into the MSB XOR the carry out of the MSB, using the effective (possibly inverted) B.
REQ-025 Arithmetic is modulo 2^WIDTH; COUT carries the bit-WIDTH result.

Reset
REQ-026 RESETN=0 SHALL immediately force state IDLE and BUSY=0, DONE=0, S=0, COUT=0, OVF=0, counter=0, regardless of CLOCK.
REQ-027 Reset during RUN SHALL abort the operation with no DONE pulse; the first START after release begins a fresh operation.

Structure
REQ-028 The state encoding (IDLE/RUN/FIN) and the MODE_ADD/MODE_SUB constants SHALL live in a shared package, adder_pkg.
REQ-029 The DIGIT-bit slice adder SHALL be a sub-module, digit_adder (parametrised width, ripple of full-adder equations, outputs sum, carry-out and carry into MSB).
REQ-030 The counter width SHALL be clog2(N), minimum 1 bit.

Verification (WIDTH=8, DIGIT=1 unless stated)
REQ-031 Add: A=8'hFF, B=8'h01, CIN=0, START pulse -> BUSY high for 8 cycles, DONE high 9 cycles after START, S=8'h00, COUT=1, OVF=0.
REQ-032 Signed overflow: A=8'h7F, B=8'h01, CIN=0 -> S=8'h80, COUT=0, OVF=1; then MODE=1, A=8'h80, B=8'h01 -> S=8'h7F, COUT=1, OVF=1.
REQ-033 START re-pulsed and operands changed mid-RUN -> ignored; result matches the first operands; exactly one DONE pulse.
REQ-034 RESETN low at cycle 4 of RUN -> outputs zero immediately; no DONE; a subsequent A=8'h03, B=8'h04 add gives S=8'h07.
REQ-035 DIGIT=4: A=8'h9C, B=8'h64, CIN=1 -> DONE 3 cycles after START, S=8'h01, COUT=1, OVF=0.
REQ-036 Back-to-back: START held high in FIN -> the new operation starts with no IDLE cycle; two DONE pulses N+1 cycles apart.
